// File: rtl/noc_pkg.sv
// ============================================================================
// noc_pkg : flit format, port ids and packetizer FSM state shared across the NoC
// Rev 1.0
// ============================================================================
`default_nettype none

package noc_pkg;

    localparam logic [1:0] FLIT_HEAD = 2'b00;
    localparam logic [1:0] FLIT_BODY = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b10;
    localparam logic [1:0] FLIT_IDLE = 2'b11;

    localparam int PORT_NORTH = 0;
    localparam int PORT_EAST  = 1;
    localparam int PORT_SOUTH = 2;
    localparam int PORT_WEST  = 3;
    localparam int PORT_LOCAL = 4;

    // Bit positions inside the 8-bit flit: [7:5]=Y, [4:2]=X or [7:2]=payload, [1:0]=type
    localparam int TYPE_LSB = 0;
    localparam int X_LSB    = 2;
    localparam int Y_LSB    = 5;
    localparam int PL_LSB   = 2;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } pkt_state_e;

endpackage

`default_nettype wire

// File: rtl/flit_packetizer_credit_counter.sv
// ============================================================================
// credit_counter : saturating up/down credit count for one downstream buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module credit_counter #(
    parameter int BUF_DEPTH = 4,
    parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          consume,
    input  logic          credit_in,
    output logic [CW-1:0] credit_cnt,
    output logic          has_credit
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A consume coinciding with a returned credit nets to zero; returns at full are dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (consume && !credit_in) begin
            cnt_d = cnt_q - 1'b1;
        end else if (credit_in && !consume && (cnt_q != CW'(BUF_DEPTH))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= CW'(BUF_DEPTH);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign credit_cnt = cnt_q;
    assign has_credit = (cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/flit_packetizer.sv
// ============================================================================
// flit_packetizer : local-port injection engine, head/body/tail flit encoder
// with credit flow control. Optional tail counter: FLIT_PACKETIZER_PKT_CNT_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module flit_packetizer
    import noc_pkg::*;
#(
    parameter int IP_SIZE   = 8,
    parameter int MESH_DIM  = 4,
    parameter int ROUTER_ID = 0,
    parameter int PKT_LEN   = 4,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_dest_x,
    input  logic [2:0]         req_dest_y,
    input  logic               pl_valid,
    output logic               pl_ready,
    input  logic [5:0]         pl_data,
    output logic [IP_SIZE-1:0] flit_out,
    output logic               flit_valid,
    input  logic               credit_in,
    output logic               busy
`ifdef FLIT_PACKETIZER_PKT_CNT_EN
    ,
    output logic [CNT_W-1:0]   pkt_sent_cnt
`endif
);

    localparam int BEAT_W = (PKT_LEN <= 2) ? 1 : $clog2(PKT_LEN);
    localparam int CRED_W = $clog2(BUF_DEPTH + 1);

    pkt_state_e          state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [IP_SIZE-1:0]  flit_q, flit_d;
    logic                valid_q, valid_d;
    logic                has_credit;
    logic [CRED_W-1:0]   credit_cnt;
    logic                req_hs, pl_hs, is_tail;

    credit_counter #(
        .BUF_DEPTH (BUF_DEPTH),
        .CW        (CRED_W)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .consume    (req_hs | pl_hs),
        .credit_in  (credit_in),
        .credit_cnt (credit_cnt),
        .has_credit (has_credit)
    );

    assign req_ready = (state_q == ST_IDLE)    && has_credit;
    assign pl_ready  = (state_q == ST_PAYLOAD) && has_credit;
    assign req_hs    = req_valid && req_ready;
    assign pl_hs     = pl_valid && pl_ready;
    assign is_tail   = (beat_q == BEAT_W'(PKT_LEN - 2));

    always_comb begin
        state_d                   = state_q;
        beat_d                    = beat_q;
        valid_d                   = 1'b0;
        flit_d                    = '0;
        flit_d[TYPE_LSB +: 2]     = FLIT_IDLE;
        if (req_hs) begin
            flit_d[Y_LSB +: 3]    = req_dest_y;
            flit_d[X_LSB +: 3]    = req_dest_x;
            flit_d[TYPE_LSB +: 2] = FLIT_HEAD;
            valid_d               = 1'b1;
            beat_d                = '0;
            state_d               = ST_PAYLOAD;
        end else if (pl_hs) begin
            flit_d[PL_LSB +: 6]   = pl_data;
            flit_d[TYPE_LSB +: 2] = is_tail ? FLIT_TAIL : FLIT_BODY;
            valid_d               = 1'b1;
            beat_d                = beat_q + 1'b1;
            if (is_tail) begin
                state_d           = ST_IDLE;
                beat_d            = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            valid_q <= 1'b0;
            flit_q  <= IP_SIZE'(FLIT_IDLE);
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            flit_q  <= flit_d;
        end
    end

    assign flit_out   = flit_q;
    assign flit_valid = valid_q;
    assign busy       = (state_q != ST_IDLE);

`ifdef FLIT_PACKETIZER_PKT_CNT_EN
    logic [CNT_W-1:0] pkt_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt_q <= '0;
        end else if (pl_hs && is_tail) begin
            pkt_cnt_q <= pkt_cnt_q + 1'b1;
        end
    end

    assign pkt_sent_cnt = pkt_cnt_q;
`else
`endif

`ifndef SYNTHESIS
    // Out-of-mesh destinations are still encoded as given; flag them in simulation only.
    always @(posedge clk) begin
        if (rst) begin
            assert (PKT_LEN >= 2 && IP_SIZE == 8 && CNT_W > 0 && ROUTER_ID < MESH_DIM * MESH_DIM)
            else $error("flit_packetizer: illegal parameter set");
            if (req_hs) begin
                assert (int'(req_dest_x) < MESH_DIM && int'(req_dest_y) < MESH_DIM)
                else $error("flit_packetizer: destination (%0d,%0d) outside mesh", req_dest_x, req_dest_y);
            end
        end
    end
`endif

endmodule

`default_nettype wire
